mem_arbiter: RTL

- Shares the single-port `ram` (1-cycle read latency) between NREQ requesters: CPU fetch/data port, string/UART DMA, and debug loader.
- Round-robin arbitration with optional lock for bursts, such as multi-word string reads.
- Converts byte addresses to word addresses and flags misaligned or out-of-range accesses.
- Sits between requesters and `ram`. Top level ties `ram_wdata`/`ram_rdata` onto the ram's tri-state data bus.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_rr_pick.sv | 43 ++++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the ram arbiter and its round-robin picker.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_CAPTURE
  } arb_state_t;

  localparam int ARB_MAX_REQ   = 4;
  localparam int ARB_IW        = $clog2(ARB_MAX_REQ);
  localparam int ARB_DWIDTH    = 32;
  localparam int ARB_CPUAWIDTH = 32;
  localparam int ARB_AWIDTH    = 10;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational winner select: a requesting lock owner wins outright, otherwise
// the first requester after the round-robin pointer, wrapping at NREQ.
module mem_arbiter_rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]   req,
  input  logic [ARB_IW-1:0] ptr,
  input  logic [ARB_IW-1:0] owner,
  input  logic              owner_vld,
  output logic              found,
  output logic [NREQ-1:0]   win_oh,
  output logic [ARB_IW-1:0] win_idx
);

  logic [ARB_MAX_REQ-1:0] req_x;
  logic [ARB_IW:0]        cand;

  always_comb begin
    req_x   = ARB_MAX_REQ'(req);
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    if (owner_vld && req_x[owner]) begin
      found   = 1'b1;
      win_idx = owner;
    end
    // k = 1..NREQ visits every requester once, starting just after ptr
    for (int k = 1; k <= ARB_MAX_REQ; k++) begin
      cand = {1'b0, ptr} + (ARB_IW+1)'(k);
      if (cand >= (ARB_IW+1)'(NREQ)) cand = cand - (ARB_IW+1)'(NREQ);
      if (!found && (k <= NREQ) && req_x[cand[ARB_IW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[ARB_IW-1:0];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      win_oh[i] = found && (win_idx == ARB_IW'(i));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with burst lock sharing a 1-cycle-latency single-port ram;
// converts byte to word addresses and rejects misaligned/out-of-range accesses.
//
//   state       | meaning
//   ARB_IDLE    | sample req, grant winner, register ram command
//   ARB_ACCESS  | ram enable high; writes/rejects finish next cycle
//   ARB_CAPTURE | read data returning from ram, captured into rdata
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DWIDTH    = ARB_DWIDTH,
  parameter int CPUAWIDTH = ARB_CPUAWIDTH,
  parameter int AWIDTH    = ARB_AWIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           we,
  input  logic [NREQ-1:0]           lock,
  input  logic [NREQ*CPUAWIDTH-1:0] addr,
  input  logic [NREQ*DWIDTH-1:0]    wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic                      err,
  output logic [DWIDTH-1:0]         rdata,
  output logic [AWIDTH-1:0]         ram_addr,
  output logic                      ram_rdEn,
  output logic                      ram_wrEn,
  output logic [DWIDTH-1:0]         ram_wdata,
  input  logic [DWIDTH-1:0]         ram_rdata
);

  arb_state_t          state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d, done_q, done_d;
  logic                err_q, err_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d, ram_wdata_q, ram_wdata_d;
  logic [AWIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_rd_q, ram_rd_d, ram_wr_q, ram_wr_d;
  logic [ARB_IW-1:0]   ptr_q, ptr_d, owner_q, owner_d, w_q, w_d;
  logic                owner_vld_q, owner_vld_d;

  logic [ARB_MAX_REQ-1:0] req_x, we_x, lock_x;
  logic [ARB_IW-1:0]      owner_eff, win_idx;
  logic                   owner_eff_vld, found, reject;
  logic [NREQ-1:0]        win_oh, w_oh;
  logic [CPUAWIDTH-1:0]   addr_w;
  logic [DWIDTH-1:0]      wdata_w;

  // A completion with lock high hands ownership to the finisher in time for the
  // arbitration happening in that same done cycle.
  always_comb begin
    req_x         = ARB_MAX_REQ'(req);
    we_x          = ARB_MAX_REQ'(we);
    lock_x        = ARB_MAX_REQ'(lock);
    owner_eff     = owner_q;
    owner_eff_vld = owner_vld_q;
    if (|done_q) begin
      owner_eff     = w_q;
      owner_eff_vld = lock_x[w_q];
    end
  end

  mem_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req       (req),
    .ptr       (ptr_q),
    .owner     (owner_eff),
    .owner_vld (owner_eff_vld),
    .found     (found),
    .win_oh    (win_oh),
    .win_idx   (win_idx)
  );

  always_comb begin
    addr_w  = '0;
    wdata_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_oh[i] = (w_q == ARB_IW'(i));
      if (win_idx == ARB_IW'(i)) begin
        addr_w  = addr[i*CPUAWIDTH +: CPUAWIDTH];
        wdata_w = wdata[i*DWIDTH +: DWIDTH];
      end
    end
    reject = (|addr_w[1:0]) || (|addr_w[CPUAWIDTH-1:AWIDTH+2]);
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    done_d      = '0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    w_d         = w_q;
    case (state_q)
      ARB_IDLE: begin
        owner_d     = owner_eff;
        owner_vld_d = owner_eff_vld && req_x[owner_eff];
        if (found) begin
          gnt_d       = win_oh;
          w_d         = win_idx;
          ptr_d       = win_idx;
          ram_addr_d  = addr_w[AWIDTH+1:2];
          ram_wdata_d = wdata_w;
          ram_rd_d    = !reject && !we_x[win_idx];
          ram_wr_d    = !reject && we_x[win_idx];
          state_d     = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (ram_rd_q) begin
          state_d = ARB_CAPTURE;
        end else begin
          // neither enable set means the access was rejected at grant time
          state_d = ARB_IDLE;
          done_d  = w_oh;
          err_d   = !ram_wr_q;
          if (!ram_wr_q) rdata_d = '0;
        end
      end
      ARB_CAPTURE: begin
        rdata_d = ram_rdata;
        done_d  = w_oh;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ptr_q       <= ARB_IW'(NREQ-1);
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      w_q         <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      w_q         <= w_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_rdEn  = ram_rd_q;
  assign ram_wrEn  = ram_wr_q;

endmodule
